// File: rtl/dragster_spi_pkg.sv
// rtl/dragster_spi_pkg.sv - shared constants and state encoding for the Dragster SPI master
package dragster_spi_pkg;

    localparam int unsigned FRAME_WIDTH_DEF = 16;

    // Register-access frame layout: [15] R/W (1=read), [14:8] address, [7:0] data
    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_phase_counter.sv
// rtl/spi_phase_counter.sv - divider that marks the first and last cycle of each DIV-cycle phase
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   en_i           count while high; held at zero while low
//   phase_first_o  high in the first cycle of a phase
//   phase_end_o    high in the last cycle of a phase (counter wraps next cycle)
module spi_phase_counter #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic phase_first_o,
    output logic phase_end_o
);

    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With DIV=1 LAST is zero, so every enabled cycle is both first and last;
    // the counter never leaves zero and cannot underflow.
    assign phase_first_o = en_i && (cnt_q == '0);
    assign phase_end_o   = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || phase_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dragster_spi_master.sv
// rtl/dragster_spi_master.sv - mode-0 MSB-first SPI master for Dragster sensor register frames
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   start, slave_sel,       frame request; tx_data and slave_sel captured when idle
//   tx_data
//   rx_data, done, busy     captured frame (valid from done), end pulse, activity flag
//   miso, mosi, sclk, ss_n  serial bus; sclk idles low, ss_n active low
module dragster_spi_master import dragster_spi_pkg::*; #(
    parameter int unsigned CLK_DIVIDER = 4,
    parameter int unsigned FRAME_WIDTH = FRAME_WIDTH_DEF,
    parameter int unsigned SLAVE_COUNT = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   slave_sel,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   busy,
    output logic                   done,
    input  logic                   miso,
    output logic                   mosi,
    output logic                   sclk,
    output logic [SLAVE_COUNT-1:0] ss_n
);

    localparam int unsigned          BW       = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [BW-1:0]        LAST_BIT = BW'(FRAME_WIDTH - 1);
    localparam logic [SLAVE_COUNT-1:0] ONE_HOT0 = SLAVE_COUNT'(1);

    state_t                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SLAVE_COUNT-1:0] ss_n_q, ss_n_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic phase_first;
    logic phase_end;

    spi_phase_counter #(
        .DIV (CLK_DIVIDER)
    ) u_phase (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .en_i          (state_q != ST_IDLE),
        .phase_first_o (phase_first),
        .phase_end_o   (phase_end)
    );

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        ss_n_d    = ss_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_sh_d   = tx_data;
                    bit_cnt_d = '0;
                    ss_n_d    = ~(ONE_HOT0 << slave_sel);
                    mosi_d    = tx_data[FRAME_WIDTH-1];
                    busy_d    = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // sclk_q doubles as the high/low half-period flag.
                if (sclk_q && phase_first) begin
                    rx_sh_d = {rx_sh_q[FRAME_WIDTH-2:0], miso};
                end
                if (phase_end) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[FRAME_WIDTH-2];
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    ss_n_d    = '1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ss_n_d  = '1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            ss_n_q    <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign mosi    = mosi_q;
    assign sclk    = sclk_q;
    assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_dragster_spi_master.sv
// tb/tb_dragster_spi_master.sv - self-checking bench for dragster_spi_master at D=4 and D=1
module tb_dragster_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start     [2];
    logic        slave_sel [2];
    logic [15:0] tx_data   [2];
    logic        miso      [2];
    logic [15:0] rx_data   [2];
    logic        busy      [2];
    logic        done      [2];
    logic        mosi      [2];
    logic        sclk      [2];
    logic [1:0]  ss_n      [2];

    logic        loop_m [2];
    logic [15:0] slv_v  [2];
    logic [15:0] slv_sh [2];
    logic        prev_sclk [2];

    int n_checks = 0;
    int n_fail   = 0;

    dragster_spi_master #(.CLK_DIVIDER(4), .FRAME_WIDTH(16), .SLAVE_COUNT(2)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .slave_sel(slave_sel[0]),
        .tx_data(tx_data[0]), .rx_data(rx_data[0]), .busy(busy[0]), .done(done[0]),
        .miso(miso[0]), .mosi(mosi[0]), .sclk(sclk[0]), .ss_n(ss_n[0])
    );

    dragster_spi_master #(.CLK_DIVIDER(1), .FRAME_WIDTH(16), .SLAVE_COUNT(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .slave_sel(slave_sel[1]),
        .tx_data(tx_data[1]), .rx_data(rx_data[1]), .busy(busy[1]), .done(done[1]),
        .miso(miso[1]), .mosi(mosi[1]), .sclk(sclk[1]), .ss_n(ss_n[1])
    );

    assign miso[0] = loop_m[0] ? mosi[0] : slv_sh[0][15];
    assign miso[1] = loop_m[1] ? mosi[1] : slv_sh[1][15];

    // Sensor model: presents its word while deselected, shifts on sclk falling edges.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ss_n[k] == 2'b11) slv_sh[k] <= slv_v[k];
            else if (prev_sclk[k] && !sclk[k]) slv_sh[k] <= {slv_sh[k][14:0], 1'b0};
            prev_sclk[k] <= sclk[k];
        end
    end

    function automatic int dv(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Reference model: ft = cycles since the accepting edge (0 = idle).
    int          ft        [2];
    logic        m_sel     [2];
    logic [15:0] m_tx      [2];
    logic [15:0] m_rx_frm  [2];
    logic [15:0] m_rx_hold [2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                ft[k]        <= 0;
                m_rx_hold[k] <= 16'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ft[k] == 0) begin
                    if (start[k]) begin
                        ft[k]       <= 1;
                        m_tx[k]     <= tx_data[k];
                        m_sel[k]    <= slave_sel[k];
                        m_rx_frm[k] <= loop_m[k] ? tx_data[k] : slv_v[k];
                    end
                end else begin
                    if (ft[k] == 34 * dv(k)) m_rx_hold[k] <= m_rx_frm[k];
                    if (ft[k] == 35 * dv(k)) ft[k] <= 0;
                    else ft[k] <= ft[k] + 1;
                end
            end
        end
    end

    function automatic logic e_sclk(input int t, input int d);
        if (t >= d + 1 && t <= 33 * d) return ((t - d - 1) % (2 * d)) < d;
        return 1'b0;
    endfunction

    function automatic logic e_mosi(input int t, input int d, input logic [15:0] tx);
        int b;
        if (t < 1 || t > 34 * d) return 1'b0;
        b = (t <= 2 * d) ? 0 : (t - 2 * d - 1) / (2 * d) + 1;
        if (b >= 16) return 1'b0;
        return tx[15 - b];
    endfunction

    function automatic logic [1:0] e_ss(input int t, input int d, input logic sel);
        if (t >= 1 && t <= 34 * d) return sel ? 2'b01 : 2'b10;
        return 2'b11;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s dut%0d got=%0h exp=%0h time=%0t", name, k, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                int t;
                int d;
                t = ft[k];
                d = dv(k);
                check("ss_n",    k, 32'(ss_n[k]),    32'(e_ss(t, d, m_sel[k])));
                check("sclk",    k, 32'(sclk[k]),    32'(e_sclk(t, d)));
                check("mosi",    k, 32'(mosi[k]),    32'(e_mosi(t, d, m_tx[k])));
                check("busy",    k, 32'(busy[k]),    32'(t >= 1 && t <= 35 * d));
                check("done",    k, 32'(done[k]),    32'(t == 34 * d + 1));
                check("rx_data", k, 32'(rx_data[k]), 32'(m_rx_hold[k]));
            end
        end
    end

    task automatic wait_idle(input int k);
        int guard;
        guard = 0;
        while (ft[k] != 0 && guard < 400) begin
            @(negedge clk);
            start[k] = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                tx_data[k]   = 16'($urandom);
                slave_sel[k] = 1'($urandom);
                start[k]     = 1'b1;
            end
            guard++;
        end
        start[k] = 1'b0;
        if (guard >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle dut%0d timeout", k);
        end
    endtask

    // Returns just after the accepting edge (cycle 0).
    task automatic launch(input int k, input logic [15:0] tx, input logic sel,
                          input logic lp, input logic [15:0] v);
        @(negedge clk);
        loop_m[k] = lp;
        slv_v[k]  = v;
        @(negedge clk);
        tx_data[k]   = tx;
        slave_sel[k] = sel;
        start[k]     = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [15:0] bits;
        int          rises;
        logic        prevs;

        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; slave_sel[k] = 1'b0; tx_data[k] = 16'h0;
            loop_m[k] = 1'b1; slv_v[k] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ss_n", k, 32'(ss_n[k]), 32'h3);
            check("rst_sclk", k, 32'(sclk[k]), 32'h0);
            check("rst_mosi", k, 32'(mosi[k]), 32'h0);
            check("rst_busy", k, 32'(busy[k]), 32'h0);
            check("rst_done", k, 32'(done[k]), 32'h0);
            check("rst_rx",   k, 32'(rx_data[k]), 32'h0);
        end
        reset_n = 1'b1;

        // Write to slave 0 with loopback; ignored starts at cycles 10 and 140.
        launch(0, 16'h0A55, 1'b0, 1'b1, 16'h0);
        bits = 16'h0; rises = 0; prevs = 1'b0;
        for (int t = 1; t <= 142; t++) begin
            @(negedge clk);
            start[0] = (t == 10 || t == 140);
            if (t == 10)  begin tx_data[0] = 16'hF00F; slave_sel[0] = 1'b1; end
            if (t == 140) begin tx_data[0] = 16'h1234; slave_sel[0] = 1'b1; end
            if (sclk[0] && !prevs) begin bits = {bits[14:0], mosi[0]}; rises++; end
            prevs = sclk[0];
            if (t == 1 || t == 136) check("w_ss_low", 0, 32'(ss_n[0]), 32'h2);
            if (t == 136) check("w_done_early", 0, 32'(done[0]), 32'h0);
            if (t == 137) begin
                check("w_ss_high", 0, 32'(ss_n[0]), 32'h3);
                check("w_done", 0, 32'(done[0]), 32'h1);
                check("w_rx", 0, 32'(rx_data[0]), 32'h0A55);
            end
            if (t == 140) check("w_busy140", 0, 32'(busy[0]), 32'h1);
            if (t == 141) begin
                check("w_busy141", 0, 32'(busy[0]), 32'h0);
                check("w_no_second", 0, 32'(ss_n[0]), 32'h3);
            end
        end
        check("w_rises", 0, 32'(rises), 32'd16);
        check("w_bits", 0, 32'(bits), 32'h0A55);

        // Read from slave 1; sensor returns 16'h00C3.
        wait_idle(0);
        launch(0, 16'h8300, 1'b1, 1'b0, 16'h00C3);
        for (int t = 1; t <= 137; t++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (t == 1 || t == 70 || t == 136) check("r_ss", 0, 32'(ss_n[0]), 32'h1);
            if (t == 137) begin
                check("r_done", 0, 32'(done[0]), 32'h1);
                check("r_rx", 0, 32'(rx_data[0]), 32'h00C3);
            end
        end

        // Reset at cycle 60 of a frame, then a clean frame.
        wait_idle(0);
        launch(0, 16'h5B3C, 1'b0, 1'b1, 16'h0);
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        check("pre_rst_mosi", 0, 32'(mosi[0]), 32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_ss_n", 0, 32'(ss_n[0]), 32'h3);
        check("arst_sclk", 0, 32'(sclk[0]), 32'h0);
        check("arst_mosi", 0, 32'(mosi[0]), 32'h0);
        check("arst_busy", 0, 32'(busy[0]), 32'h0);
        check("arst_done", 0, 32'(done[0]), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        launch(0, 16'h3C5A, 1'b1, 1'b1, 16'h0);
        for (int t = 1; t <= 137; t++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (t == 137) begin
                check("post_rst_done", 0, 32'(done[0]), 32'h1);
                check("post_rst_rx", 0, 32'(rx_data[0]), 32'h3C5A);
            end
        end

        // D=1 boundary: all-ones loopback.
        wait_idle(1);
        launch(1, 16'hFFFF, 1'b0, 1'b1, 16'h0);
        for (int t = 1; t <= 36; t++) begin
            @(negedge clk);
            start[1] = 1'b0;
            if (t == 1)  check("d1_ss", 1, 32'(ss_n[1]), 32'h2);
            if (t == 34) check("d1_done_early", 1, 32'(done[1]), 32'h0);
            if (t == 35) begin
                check("d1_done", 1, 32'(done[1]), 32'h1);
                check("d1_rx", 1, 32'(rx_data[1]), 32'hFFFF);
                check("d1_busy35", 1, 32'(busy[1]), 32'h1);
            end
            if (t == 36) check("d1_busy36", 1, 32'(busy[1]), 32'h0);
        end

        // Randomised frames on both dividers, with stray starts while busy.
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < ((k == 0) ? 12 : 40); f++) begin
                wait_idle(k);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                launch(k, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
                @(negedge clk);
                start[k] = 1'b0;
            end
            wait_idle(k);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
